// File: rtl/prio_pkg.sv
// Shared types and limits for the priority interrupt controller family.
// Optional preemption is enabled by defining PRIO_PREEMPT_EN.
package prio_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  localparam int MIN_N = 2;
  localparam int MAX_N = 32;

  function automatic logic [MAX_N-1:0] one_hot(input int unsigned k);
    logic [MAX_N-1:0] v;
    v = '0;
    v[k[4:0]] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/prio_enc.sv
// Combinational priority encoder: highest set index wins.
// Reused by other blocks; N sets the request width.
module prio_enc #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  output logic         any,
  output logic [W-1:0] idx
);

  assign any = |req;

  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) idx = W'(i);
    end
  end

endmodule

// File: rtl/priority_irq_ctrl.sv
// Edge-latching priority interrupt controller with valid/ack hand-off.
// Define PRIO_PREEMPT_EN to let a higher candidate replace a presented id.
module priority_irq_ctrl
  import prio_pkg::*;
#(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] irq,
  input  logic [N-1:0] mask,
  input  logic         ack,
  output logic         valid,
  output logic [W-1:0] id,
  output logic [N-1:0] pend
);

  state_t         state;
  logic [N-1:0]   irq_d;
  logic [N-1:0]   edges;
  logic [N-1:0]   cand;
  logic [N-1:0]   clr;
  logic [N-1:0]   pend_nx;
  logic           any;
  logic [W-1:0]   idx;
  logic           take;
  logic           drop;
  logic           pre;

  assign edges = irq & ~irq_d;
  assign cand  = pend & ~mask;

  prio_enc #(
    .N (N),
    .W (W)
  ) u_enc (
    .req (cand),
    .any (any),
    .idx (idx)
  );

  // ack only counts while something is actually presented
  assign take = (state == PRESENT) && valid && ack;
  assign drop = (state == PRESENT) && (ack || mask[id]);

  always_comb begin
    clr = '0;
    if (take) clr[id] = 1'b1;
  end

  // a new edge on the acked line re-arms it
  assign pend_nx = (pend & ~clr) | edges;

`ifdef PRIO_PREEMPT_EN
  assign pre = any && (idx > id);
`else
  assign pre = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      valid <= 1'b0;
      id    <= '0;
      pend  <= '0;
      irq_d <= '0;
    end else begin
      irq_d <= irq;
      if (!en) begin
        state <= IDLE;
        valid <= 1'b0;
      end else begin
        pend <= pend_nx;
        unique case (state)
          IDLE: begin
            if (any) begin
              id    <= idx;
              valid <= 1'b1;
              state <= PRESENT;
            end
          end
          PRESENT: begin
            if (drop) begin
              valid <= 1'b0;
              state <= IDLE;
            end else if (pre) begin
              id <= idx;
            end
          end
          default: begin
            valid <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_priority_irq_ctrl.sv
// Scoreboard bench for priority_irq_ctrl: directed cases plus random traffic.
// Expected outputs come from a request-level reference model.
module tb_priority_irq_ctrl;

  localparam int N = 8;
  localparam int W = $clog2(N);
`ifdef PRIO_PREEMPT_EN
  localparam bit PRE = 1'b1;
`else
  localparam bit PRE = 1'b0;
`endif

  typedef struct {
    bit         v;
    int         i;
    bit [N-1:0] p;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic [N-1:0] irq;
  logic [N-1:0] mask;
  logic         ack;
  logic         valid;
  logic [W-1:0] id;
  logic [N-1:0] pend;

  exp_t sbq[$];
  int   total;
  int   bad;

  // reference model state
  bit   m_seen [N];
  bit   m_pend [N];
  bit   m_show;
  int   m_id;

  priority_irq_ctrl #(
    .N (N)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .irq   (irq),
    .mask  (mask),
    .ack   (ack),
    .valid (valid),
    .id    (id),
    .pend  (pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, req, $time);
    end
  endtask

  function automatic bit [N-1:0] pack_pend();
    bit [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_pend[i];
    return v;
  endfunction

  // one clock edge of the specified behaviour, in request terms
  task automatic model_step(input bit r, input bit e, input bit [N-1:0] q,
                            input bit [N-1:0] m, input bit a);
    int  top;
    bit  rise [N];
    if (!r) begin
      for (int i = 0; i < N; i++) begin
        m_seen[i] = 0;
        m_pend[i] = 0;
      end
      m_show = 0;
      m_id   = 0;
      return;
    end
    for (int i = 0; i < N; i++) begin
      rise[i]   = q[i] && !m_seen[i];
      m_seen[i] = q[i];
    end
    if (!e) begin
      m_show = 0;
      return;
    end
    top = -1;
    for (int i = N - 1; i >= 0; i--) begin
      if (m_pend[i] && !m[i]) begin
        top = i;
        break;
      end
    end
    if (m_show && a) m_pend[m_id] = 0;
    for (int i = 0; i < N; i++) if (rise[i]) m_pend[i] = 1;
    if (!m_show) begin
      if (top >= 0) begin
        m_show = 1;
        m_id   = top;
      end
    end else if (a || m[m_id]) begin
      m_show = 0;
    end else if (PRE && top > m_id) begin
      m_id = top;
    end
  endtask

  task automatic cycle(input bit r, input bit e, input bit [N-1:0] q,
                       input bit [N-1:0] m, input bit a);
    exp_t x;
    rst_n = r;
    en    = e;
    irq   = q;
    mask  = m;
    ack   = a;
    @(posedge clk);
    model_step(r, e, q, m, a);
    x.v = m_show;
    x.i = m_id;
    x.p = pack_pend();
    sbq.push_back(x);
    #1;
  endtask

  // monitor: compare every presented output against the queued expectation
  always @(negedge clk) begin
    exp_t x;
    if (sbq.size() > 0) begin
      x = sbq.pop_front();
      check("sb_valid", int'(valid), int'(x.v));
      check("sb_pend", int'(pend), int'(x.p));
      if (x.v) check("sb_id", int'(id), x.i);
    end
  end

  initial begin
    bit [N-1:0] rq;
    bit [N-1:0] rm;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    en    = 1'b0;
    irq   = '0;
    mask  = '0;
    ack   = 1'b0;

    cycle(0, 1, 8'h00, 8'h00, 0);
    check("rst_valid", int'(valid), 0);
    check("rst_id", int'(id), 0);
    check("rst_pend", int'(pend), 0);
    cycle(1, 1, 8'h00, 8'h00, 0);

    // single request and hand-off
    cycle(1, 1, 8'h08, 8'h00, 0);
    check("single_pend_t1", int'(pend), 8'h08);
    check("single_valid_t1", int'(valid), 0);
    cycle(1, 1, 8'h08, 8'h00, 0);
    check("single_valid_t2", int'(valid), 1);
    check("single_id_t2", int'(id), 3);
    cycle(1, 1, 8'h08, 8'h00, 1);
    check("single_pend_ack", int'(pend), 0);
    check("single_valid_ack", int'(valid), 0);
    cycle(1, 1, 8'h08, 8'h00, 1);
    check("ack_ignored", int'(pend), 0);

    // edge coinciding with ack on the same line keeps it pending
    cycle(1, 1, 8'h00, 8'h00, 0);
    cycle(1, 1, 8'h08, 8'h00, 0);
    cycle(1, 1, 8'h00, 8'h00, 0);
    check("setwin_valid", int'(valid), 1);
    cycle(1, 1, 8'h08, 8'h00, 1);
    check("setwin_pend", int'(pend), 8'h08);
    check("setwin_drop", int'(valid), 0);
    cycle(0, 1, 8'h00, 8'h00, 0);

    // priority ordering 7, 5, 0
    cycle(1, 1, 8'hA1, 8'h00, 0);
    cycle(1, 1, 8'hA1, 8'h00, 0);
    check("prio_first", int'(id), 7);
    cycle(1, 1, 8'hA1, 8'h00, 1);
    cycle(1, 1, 8'hA1, 8'h00, 0);
    check("prio_second", int'(id), 5);
    cycle(1, 1, 8'hA1, 8'h00, 1);
    cycle(1, 1, 8'hA1, 8'h00, 0);
    check("prio_third", int'(id), 0);
    cycle(1, 1, 8'hA1, 8'h00, 1);
    check("prio_empty", int'(pend), 0);
    cycle(0, 1, 8'h00, 8'h00, 0);

    // masking
    cycle(1, 1, 8'h84, 8'h80, 0);
    cycle(1, 1, 8'h84, 8'h80, 0);
    check("mask_id", int'(id), 2);
    cycle(1, 1, 8'h84, 8'h80, 1);
    check("mask_pend", int'(pend), 8'h80);
    cycle(1, 1, 8'h84, 8'h80, 0);
    check("mask_hold", int'(valid), 0);
    cycle(1, 1, 8'h84, 8'h00, 0);
    check("unmask_valid", int'(valid), 1);
    check("unmask_id", int'(id), 7);
    cycle(1, 1, 8'h84, 8'h80, 0);
    check("mask_rise_drop", int'(valid), 0);
    check("mask_rise_pend", int'(pend), 8'h80);
    cycle(0, 1, 8'h00, 8'h00, 0);

    // preemption
    cycle(1, 1, 8'h02, 8'h00, 0);
    cycle(1, 1, 8'h02, 8'h00, 0);
    check("pre_first", int'(id), 1);
    cycle(1, 1, 8'h42, 8'h00, 0);
    cycle(1, 1, 8'h42, 8'h00, 0);
    check("pre_valid", int'(valid), 1);
    check("pre_id", int'(id), PRE ? 6 : 1);

    // reset while presenting
    cycle(0, 1, 8'h42, 8'h00, 0);
    check("rst_pr_valid", int'(valid), 0);
    check("rst_pr_id", int'(id), 0);
    check("rst_pr_pend", int'(pend), 0);

    // disable
    cycle(1, 1, 8'h00, 8'h10, 0);
    cycle(1, 1, 8'h10, 8'h10, 0);
    cycle(1, 0, 8'hFF, 8'h00, 0);
    check("dis_valid", int'(valid), 0);
    check("dis_pend", int'(pend), 8'h10);
    cycle(1, 0, 8'hFF, 8'h00, 0);
    cycle(1, 1, 8'hFF, 8'h00, 0);
    check("dis_noedge", int'(pend), 8'h10);
    check("reen_id", int'(id), 4);
    cycle(0, 1, 8'h00, 8'h00, 0);

    // random traffic
    rq = '0;
    for (int k = 0; k < 600; k++) begin
      rq = rq ^ (8'($urandom) & 8'($urandom));
      rm = ($urandom_range(0, 3) == 0) ? (8'($urandom) & 8'($urandom)) : '0;
      cycle($urandom_range(0, 99) != 0, $urandom_range(0, 9) != 0,
            rq, rm, $urandom_range(0, 1) == 1);
    end

    @(negedge clk);
    @(negedge clk);
    check("sb_drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/priority_irq_ctrl.md
PRIORITY_IRQ_CTRL -- requirements
Module: priority_irq_ctrl

Interface
REQ-001 SHALL have parameter N, default 8, giving the number of request inputs (2..32).
REQ-002 SHALL have parameter W, default $clog2(N), giving the id width; not overridden by users.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port en  input  1  block enable.
REQ-006 SHALL have port irq  input  N  request lines, level inputs, rising-edge sensitive.
REQ-007 SHALL have port mask  input  N  1 = line excluded from selection.
REQ-008 SHALL have port ack  input  1  consumer accepts the presented id.
REQ-009 SHALL have port valid  output  1  id is presented.
REQ-010 SHALL have port id  output  W  index of the presented request, registered.
REQ-011 SHALL have port pend  output  N  registered pending vector.

Function
REQ-012 SHALL register irq into irq_d each cycle and detect rising edges as irq & ~irq_d.
REQ-013 SHALL set pend[i] on a rising edge of irq[i] when en=1, regardless of mask[i].
REQ-014 SHALL select candidates as pend & ~mask, with the highest index having highest priority.
REQ-015 SHALL use a two-state FSM: IDLE and PRESENT.
REQ-016 SHALL, in IDLE with en=1 and a non-empty candidate set, load id with the winner, set valid=1, and go to PRESENT next cycle.
REQ-017 SHALL, in PRESENT with ack=1, clear pend[id], drop valid, and return to IDLE; back-to-back requests re-present no earlier than the cycle after.
REQ-018 SHALL, in PRESENT, keep valid and id stable until ack arrives, except as stated in REQ-019 and REQ-025.
REQ-019 SHALL, if mask[id] rises while in PRESENT without ack, drop valid next cycle, return to IDLE, and leave pend[id] set.
REQ-020 SHALL have a latency of two cycles from the irq edge being sampled to valid=1: pend updates at t+1, valid at t+2.
REQ-021 SHALL ignore ack when valid=0.
REQ-022 SHALL, if an edge on bit k coincides with an ack clearing bit k, leave pend[k] set (set wins).
REQ-023 SHALL, when en=0, latch no new edges, hold pend, force valid=0, and go to IDLE next cycle; irq_d keeps sampling.

Reset
REQ-024 SHALL, when rst_n=0 at a clock edge, set state=IDLE, valid=0, id=0, pend=0, and irq_d=0; a line already high at reset release therefore registers as an edge.

Configuration
REQ-025 SHALL, when macro PRIO_PREEMPT_EN is defined, replace id while in PRESENT whenever a higher-index unmasked candidate appears (valid stays 1; an ack in the same cycle applies to the old id).
REQ-026 SHALL, when PRIO_PREEMPT_EN is undefined, never change id while in PRESENT.

Structure
REQ-027 SHALL define the state enum (IDLE, PRESENT) and the maximum-N constant in shared package prio_pkg.
REQ-028 SHALL instantiate one combinational sub-module, prio_enc, parametrised by N, with outputs any and idx; it is reused by later blocks.

Verification
REQ-029 SHALL cover a single request: irq[3] 0->1 -> pend=0x08 at t+1, valid=1 and id=3 at t+2; ack -> pend=0, valid=0.
REQ-030 SHALL cover priority: simultaneous edges on bits 7, 5 and 0 -> ids presented in order 7, 5, 0 across three ack cycles.
REQ-031 SHALL cover masking: mask=0x80 with edges on bits 7 and 2 -> id=2 only; clearing mask afterwards -> id=7 presented.
REQ-032 SHALL cover preemption: present id=1, then an edge on bit 6 -> id stays 1 without PRIO_PREEMPT_EN and becomes 6 with it.
REQ-033 SHALL cover disable and reset: en=0 with irq=0xFF -> valid=0 and pend unchanged; rst_n=0 while in PRESENT -> all outputs 0 on the next edge.
